// File: rtl/pim_bus_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : pim_bus_pkg                                                   |
// | Brief    : Shared types and constants for the PIM command bridge.        |
// |            Optional feature macro: PIM_CMD_BRIDGE_ERR_EN (range check).  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package pim_bus_pkg;

  // One queued core request: direction, address and write payload.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } pim_cmd_t;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2
  } pim_state_e;

  // Peripheral window checked when the range check is enabled.
  localparam logic [31:0] PIM_BASE      = 32'h4000_0000;
  localparam logic [31:0] PIM_SIZE      = 32'h0001_0000;
  // Address 0 on the peripheral port means "no command this cycle".
  localparam logic [31:0] PIM_IDLE_ADDR = 32'h0000_0000;

  // True when a request must not reach the peripheral (it still gets a response).
  function automatic logic pim_addr_blocked(input logic [31:0] addr);
`ifdef PIM_CMD_BRIDGE_ERR_EN
    return (addr == PIM_IDLE_ADDR) || (addr < PIM_BASE) ||
           ((addr - PIM_BASE) >= PIM_SIZE);
`else
    return (addr == PIM_IDLE_ADDR);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/pim_cmd_fifo.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : pim_cmd_fifo                                                  |
// | Brief    : Synchronous FIFO of pim_cmd_t with occupancy count.           |
// |            Head is readable combinationally (first-word fall-through).  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module pim_cmd_fifo
  import pim_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push,
  input  pim_cmd_t                    push_data,
  input  logic                        pop,
  output pim_cmd_t                    head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  pim_cmd_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer advance (modulo depth) and occupancy tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/pim_cmd_bridge.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : pim_cmd_bridge                                                |
// | Brief    : Core req/gnt/rvalid bus to PIM peripheral command port.       |
// |            Queues requests, issues one command per cycle in order and    |
// |            returns read data after RD_LATENCY cycles.                    |
// |            Optional: define PIM_CMD_BRIDGE_ERR_EN for address range      |
// |            checking with err_o reporting.                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module pim_cmd_bridge
  import pim_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] peri_address_o,
  output logic [31:0] peri_data_o,
  input  logic [31:0] peri_data_i
);

  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = 2;  // holds RD_LATENCY-1 for RD_LATENCY in 1..4

  pim_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cur_is_read;

  pim_cmd_t          in_cmd;
  pim_cmd_t          fifo_head;
  pim_cmd_t          next_cmd;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              accept;
  logic              push;
  logic              pop;
  logic              have_cmd;
  logic              slot_open;
  logic              issue;
  logic              next_blocked;
  logic              next_is_read;

  assign gnt_o  = !fifo_full;
  assign accept = req_i && gnt_o;
  assign in_cmd = '{we: we_i, addr: addr_i, wdata: wdata_i};

  // When the queue is empty an accepted request bypasses it so it reaches the
  // peripheral in the very next cycle; otherwise the queue head goes first.
  assign push = accept && !(issue && fifo_empty);
  assign pop  = issue && !fifo_empty;

  pim_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (in_cmd),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Select the next command and decide whether the next cycle can carry it.
  // A read response cycle may only overlap with another read issue: a write
  // or blocked command answers in its own issue cycle, which would collide
  // with the read response, so it waits one cycle (via IDLE).
  always_comb begin
    next_cmd     = fifo_empty ? in_cmd : fifo_head;
    next_blocked = pim_addr_blocked(next_cmd.addr);
    next_is_read = !next_cmd.we && !next_blocked;
    have_cmd     = (fifo_count != '0) || accept;
    slot_open    = 1'b0;
    case (state)
      ST_IDLE:    slot_open = 1'b1;
      ST_ISSUE:   slot_open = !cur_is_read;
      ST_RD_WAIT: slot_open = (wait_cnt == '0) && next_is_read;
      default:    slot_open = 1'b0;
    endcase
    issue = slot_open && have_cmd;
  end

  // Issue FSM with registered peripheral and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      cur_is_read    <= 1'b0;
      rvalid_o       <= 1'b0;
      rdata_o        <= '0;
      err_o          <= 1'b0;
      peri_address_o <= PIM_IDLE_ADDR;
      peri_data_o    <= '0;
    end else begin
      rvalid_o       <= 1'b0;
      rdata_o        <= '0;
      err_o          <= 1'b0;
      peri_address_o <= PIM_IDLE_ADDR;
      peri_data_o    <= '0;

      if (state == ST_ISSUE && cur_is_read) begin
        state       <= ST_RD_WAIT;
        wait_cnt    <= WAIT_W'(RD_LATENCY - 1);
        cur_is_read <= 1'b0;
      end else if (state == ST_RD_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end else begin
        // Read data is valid on the bus in the last wait cycle.
        if (state == ST_RD_WAIT) begin
          rvalid_o <= 1'b1;
          rdata_o  <= peri_data_i;
        end
        if (issue) begin
          state       <= ST_ISSUE;
          cur_is_read <= next_is_read;
          if (!next_blocked) begin
            peri_address_o <= next_cmd.addr;
            peri_data_o    <= next_cmd.we ? next_cmd.wdata : 32'h0;
          end
          if (!next_is_read) begin
            rvalid_o <= 1'b1;
`ifdef PIM_CMD_BRIDGE_ERR_EN
            err_o    <= next_blocked;
`endif
          end
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pim_cmd_bridge.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_pim_cmd_bridge                                             |
// | Brief    : Directed self-checking bench for pim_cmd_bridge. Two DUTs    |
// |            share stimulus: RD_LATENCY=2 and RD_LATENCY=4.                |
// |            Honours PIM_CMD_BRIDGE_ERR_EN when defined.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_pim_cmd_bridge;

`ifdef PIM_CMD_BRIDGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] peri_data_i = '0;

  logic        gnt2, rvalid2, err2;
  logic [31:0] rdata2, paddr2, pdata2;
  logic        gnt4, rvalid4, err4;
  logic [31:0] rdata4, paddr4, pdata4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pim_cmd_bridge #(.FIFO_DEPTH(4), .RD_LATENCY(2)) u_dut2 (
    .clk_i (clk), .rst_ni (rst_ni), .req_i (req_i), .gnt_o (gnt2),
    .we_i (we_i), .addr_i (addr_i), .wdata_i (wdata_i),
    .rvalid_o (rvalid2), .rdata_o (rdata2), .err_o (err2),
    .peri_address_o (paddr2), .peri_data_o (pdata2), .peri_data_i (peri_data_i)
  );

  pim_cmd_bridge #(.FIFO_DEPTH(4), .RD_LATENCY(4)) u_dut4 (
    .clk_i (clk), .rst_ni (rst_ni), .req_i (req_i), .gnt_o (gnt4),
    .we_i (we_i), .addr_i (addr_i), .wdata_i (wdata_i),
    .rvalid_o (rvalid4), .rdata_o (rdata4), .err_o (err4),
    .peri_address_o (paddr4), .peri_data_o (pdata4), .peri_data_i (peri_data_i)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step();
    checks++; if (gnt2 !== 1'b1) begin errors++; $display("FAIL reset_gnt2: got %b want 1", gnt2); end
    checks++; if (gnt4 !== 1'b1) begin errors++; $display("FAIL reset_gnt4: got %b want 1", gnt4); end
    checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err2); end
    checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata2); end
    checks++; if (paddr2 !== 32'h0 || pdata2 !== 32'h0) begin
      errors++; $display("FAIL reset_peri: got %h/%h want 0/0", paddr2, pdata2);
    end
  endtask

  task automatic test_single_write();
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h4000_0010; wdata_i = 32'hA5A5_0001;
    checks++; if (gnt2 !== 1'b1) begin errors++; $display("FAIL sw_gnt: got %b want 1", gnt2); end
    step();
    req_i = 1'b0;
    checks++; if (paddr2 !== 32'h4000_0010) begin errors++; $display("FAIL sw_addr: got %h want 40000010", paddr2); end
    checks++; if (pdata2 !== 32'hA5A5_0001) begin errors++; $display("FAIL sw_data: got %h want a5a50001", pdata2); end
    checks++; if (rvalid2 !== 1'b1) begin errors++; $display("FAIL sw_rvalid: got %b want 1", rvalid2); end
    checks++; if (rdata2 !== 32'h0 || err2 !== 1'b0) begin
      errors++; $display("FAIL sw_rdata_err: got %h/%b want 0/0", rdata2, err2);
    end
    step();
    checks++; if (paddr2 !== 32'h0 || pdata2 !== 32'h0) begin
      errors++; $display("FAIL sw_idle_after: got %h/%h want 0/0", paddr2, pdata2);
    end
    checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL sw_rvalid_after: got %b want 0", rvalid2); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        req_i = 1'b1; we_i = 1'b1;
        addr_i = 32'h4000_0100 + 32'(i * 4);
        wdata_i = 32'hD000_0000 + 32'(i);
        checks++; if (gnt2 !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, gnt2); end
      end else begin
        req_i = 1'b0;
      end
      if (i > 0) begin
        checks++; if (paddr2 !== 32'h4000_0100 + 32'((i - 1) * 4)) begin
          errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i - 1, paddr2, 32'h4000_0100 + 32'((i - 1) * 4));
        end
        checks++; if (pdata2 !== 32'hD000_0000 + 32'(i - 1)) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i - 1, pdata2, 32'hD000_0000 + 32'(i - 1));
        end
        checks++; if (rvalid2 !== 1'b1) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b want 1", i - 1, rvalid2); end
      end
      step();
    end
    checks++; if (paddr2 !== 32'h0) begin errors++; $display("FAIL b2b_idle: got %h want 0", paddr2); end
  endtask

  task automatic test_read();
    int wr_seen;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4000_0020; wdata_i = 32'h0;
    step();  // cycle I: read on the bus
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h4000_0030; wdata_i = 32'hBEEF_0001;
    checks++; if (paddr2 !== 32'h4000_0020 || pdata2 !== 32'h0) begin
      errors++; $display("FAIL rd_issue: got %h/%h want 40000020/0", paddr2, pdata2);
    end
    checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL rd_rvalid_I: got %b want 0", rvalid2); end
    checks++; if (gnt2 !== 1'b1) begin errors++; $display("FAIL rd_gnt_queue: got %b want 1", gnt2); end
    step();  // I+1
    req_i = 1'b0;
    checks++; if (paddr2 !== 32'h0 || rvalid2 !== 1'b0) begin
      errors++; $display("FAIL rd_wait1: got addr %h rvalid %b want 0/0", paddr2, rvalid2);
    end
    step();  // I+2: peripheral presents read data
    peri_data_i = 32'h1234_5678;
    checks++; if (paddr2 !== 32'h0 || rvalid2 !== 1'b0) begin
      errors++; $display("FAIL rd_wait2: got addr %h rvalid %b want 0/0", paddr2, rvalid2);
    end
    step();  // I+3: response
    peri_data_i = 32'h0;
    checks++; if (rvalid2 !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", rvalid2); end
    checks++; if (rdata2 !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata: got %h want 12345678", rdata2); end
    wr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (paddr2 === 32'h4000_0030 && pdata2 === 32'hBEEF_0001) wr_seen++;
      step();
    end
    checks++; if (wr_seen != 1) begin errors++; $display("FAIL rd_queued_write: seen %0d times want 1", wr_seen); end
  endtask

  task automatic test_full();
    logic [31:0] exp_addr [6];
    int sent, resp, iss_idx, seq_err, rsp_err, low_cycles;
    bit low_at5;
    exp_addr[0] = 32'h4000_0040;
    for (int k = 1; k < 6; k++) exp_addr[k] = 32'h4000_0200 + 32'((k - 1) * 4);
    peri_data_i = 32'hCAFE_0004;
    sent = 0; resp = 0; iss_idx = 0; seq_err = 0; rsp_err = 0; low_cycles = 0; low_at5 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (rvalid4 === 1'b1) begin
        if (resp == 0) begin
          if (rdata4 !== 32'hCAFE_0004 || err4 !== 1'b0) rsp_err++;
        end else if (rdata4 !== 32'h0 || err4 !== 1'b0) begin
          rsp_err++;
        end
        resp++;
      end
      if (paddr4 !== 32'h0) begin
        if (iss_idx >= 6) seq_err++;
        else if (paddr4 !== exp_addr[iss_idx]) seq_err++;
        else if (iss_idx == 0 && pdata4 !== 32'h0) seq_err++;
        else if (iss_idx > 0 && pdata4 !== 32'h5000_0000 + 32'(iss_idx - 1)) seq_err++;
        iss_idx++;
      end
      if (sent < 6) begin
        req_i = 1'b1; we_i = (sent != 0); addr_i = exp_addr[sent];
        wdata_i = (sent == 0) ? 32'h0 : 32'h5000_0000 + 32'(sent - 1);
        if (gnt4 === 1'b1) sent++;
        else begin
          low_cycles++;
          if (c == 5) low_at5 = 1'b1;
        end
      end else begin
        req_i = 1'b0;
      end
      step();
    end
    peri_data_i = 32'h0;
    checks++; if (!low_at5) begin errors++; $display("FAIL full_gnt_low: gnt4 not low when FIFO full (cycle 5)"); end
    checks++; if (low_cycles < 1 || low_cycles > 2) begin
      errors++; $display("FAIL full_low_cycles: got %0d want 1..2", low_cycles);
    end
    checks++; if (sent != 6) begin errors++; $display("FAIL full_accepted: got %0d want 6", sent); end
    checks++; if (seq_err != 0 || iss_idx != 6) begin
      errors++; $display("FAIL full_issue_seq: issued %0d errs %0d want 6/0", iss_idx, seq_err);
    end
    checks++; if (resp != sent || rsp_err != 0) begin
      errors++; $display("FAIL full_responses: got %0d (bad %0d) want %0d (bad 0)", resp, rsp_err, sent);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4000_0050; wdata_i = 32'h0;
    step();
    for (int k = 0; k < 3; k++) begin
      we_i = 1'b1; addr_i = 32'h4000_0300 + 32'(k * 4); wdata_i = 32'h6000_0000 + 32'(k);
      checks++; if (gnt4 !== 1'b1) begin errors++; $display("FAIL rm_gnt[%0d]: got %b want 1", k, gnt4); end
      step();
    end
    req_i = 1'b0;  // dut4 now in RD_WAIT with three queued writes
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (paddr4 !== 32'h0 || pdata4 !== 32'h0 || rvalid4 !== 1'b0) begin
      errors++; $display("FAIL rm_async_out: got %h/%h/%b want 0/0/0", paddr4, pdata4, rvalid4);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      if (rvalid4 !== 1'b0 || paddr4 !== 32'h0) stray++;
      step();
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rm_no_response: got %0d stray cycles want 0", stray); end
    checks++; if (gnt4 !== 1'b1) begin errors++; $display("FAIL rm_gnt_after: got %b want 1", gnt4); end
    // Reset while a write is on the bus must clear the bus without a clock edge.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h4000_0400; wdata_i = 32'h0000_0077;
    step();
    req_i = 1'b0;
    checks++; if (paddr2 !== 32'h4000_0400) begin errors++; $display("FAIL rm_pre_addr: got %h want 40000400", paddr2); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (paddr2 !== 32'h0 || pdata2 !== 32'h0 || rvalid2 !== 1'b0) begin
      errors++; $display("FAIL rm_async_bus: got %h/%h/%b want 0/0/0", paddr2, pdata2, rvalid2);
    end
    @(posedge clk);
    #1 rst_ni = 1'b1;
    step();
  endtask

  task automatic test_addr_zero();
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'h0000_0011;
    step();
    req_i = 1'b0;
    checks++; if (paddr2 !== 32'h0 || pdata2 !== 32'h0) begin
      errors++; $display("FAIL az_bus: got %h/%h want 0/0", paddr2, pdata2);
    end
    checks++; if (rvalid2 !== 1'b1 || rdata2 !== 32'h0) begin
      errors++; $display("FAIL az_rvalid: got %b/%h want 1/0", rvalid2, rdata2);
    end
    checks++; if (err2 !== ERR_EN) begin errors++; $display("FAIL az_err: got %b want %b", err2, ERR_EN); end
    step();
    checks++; if (rvalid2 !== 1'b0 || err2 !== 1'b0) begin
      errors++; $display("FAIL az_after: got %b/%b want 0/0", rvalid2, err2);
    end
    // Nonzero address outside the peripheral window.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1000_0000; wdata_i = 32'h0000_0022;
    step();
    req_i = 1'b0;
    checks++; if (paddr2 !== (ERR_EN ? 32'h0 : 32'h1000_0000)) begin
      errors++; $display("FAIL oor_addr: got %h want %h", paddr2, ERR_EN ? 32'h0 : 32'h1000_0000);
    end
    checks++; if (rvalid2 !== 1'b1 || err2 !== ERR_EN) begin
      errors++; $display("FAIL oor_resp: got %b/%b want 1/%b", rvalid2, err2, ERR_EN);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    idle(4);
    test_back_to_back();
    idle(8);
    test_read();
    idle(12);
    test_full();
    idle(12);
    test_reset_mid();
    idle(4);
    test_addr_zero();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
